seq_accum: RTL and testbench

Parametrised sequence accumulator: on a `start` request it steps an internal term counter B through `N_STEPS` values (B = base, base+step, base+2·step, …) and adds the terms selected by `mode` into a result register W. It generalises the team's fixed 11-state "W += B on odd steps" sequencer into a restartable block with configurable width, length, start value, stride and selection mode. It sits beside the datapath as a self-contained arithmetic sequencer, with a start/busy/done handshake toward the controlling FSM.

---
 rtl/seq_accum.sv | 115 +++++++++++
 tb/tb_seq_accum.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_accum.sv
// Restartable sequence accumulator. It steps a term counter B through N_STEPS values and
// accumulates the mode-selected terms into W, using a start/busy/done handshake.
module seq_accum #(
    parameter int W_WIDTH = 6,
    parameter int N_STEPS = 11,
    parameter int IDX_W   = $clog2(N_STEPS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [W_WIDTH-1:0] base,
    input  logic [W_WIDTH-1:0] step,
    input  logic               clear,
    output logic [W_WIDTH-1:0] W,
    output logic               busy,
    output logic               done,
    output logic               ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STEPS - 1);

    state_t             state;
    logic [W_WIDTH-1:0] b_term;
    logic [IDX_W-1:0]   idx;
    logic [1:0]         mode_q;
    logic [W_WIDTH-1:0] step_q;

    logic               sel;
    logic [W_WIDTH:0]   sum_ext;

    // Mode 11 reproduces the legacy sequencer: index 0 plus every odd index.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sel     = 1'b0;
        sum_ext = {1'b0, W} + {1'b0, b_term};
        case (mode_q)
            2'b00:   sel = 1'b1;
            2'b01:   sel = idx[0];
            2'b10:   sel = ~idx[0];
            default: sel = idx[0] | (idx == '0);
        endcase
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every register
    // samples the values from before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            W      <= '0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            b_term <= '0;
            idx    <= '0;
            mode_q <= 2'b00;
            step_q <= '0;
        end else if (clear) begin
            // The abort takes priority over start and over any progress in RUN.
            state  <= IDLE;
            W      <= '0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            b_term <= '0;
            idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        W      <= '0;
                        ovf    <= 1'b0;
                        b_term <= base;
                        idx    <= '0;
                        mode_q <= mode;
                        step_q <= step;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (sel) begin
                        W   <= sum_ext[W_WIDTH-1:0];
                        ovf <= ovf | sum_ext[W_WIDTH];
                    end
                    b_term <= b_term + step_q;
                    if (idx == LAST_IDX) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_accum.sv
// Scoreboard bench for seq_accum: the default instance covers the main scenarios, and a
// second instance (W_WIDTH=8, N_STEPS=2) covers the short-run corner.
module tb_seq_accum;

    typedef struct packed {
        logic [7:0] w;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, clear;
    logic [1:0] mode;
    logic [5:0] base, step;
    logic [5:0] W;
    logic       busy, done, ovf;

    logic       start2, clear2;
    logic [1:0] mode2;
    logic [7:0] base2, step2;
    logic [7:0] W2;
    logic       busy2, done2, ovf2;

    exp_t q1[$];
    exp_t q2[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    seq_accum dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .base(base), .step(step),
        .clear(clear), .W(W), .busy(busy), .done(done), .ovf(ovf)
    );

    seq_accum #(.W_WIDTH(8), .N_STEPS(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .mode(mode2), .base(base2), .step(step2),
        .clear(clear2), .W(W2), .busy(busy2), .done(done2), .ovf(ovf2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitors: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (q1.size() == 0) begin
                check("dut unexpected done", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("dut W at done", {26'd0, W}, {24'd0, e.w});
                check("dut ovf at done", ovf, e.ovf);
            end
        end
    end

    always @(negedge clk) begin
        if (done2) begin
            if (q2.size() == 0) begin
                check("dut2 unexpected done", 1, 0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                check("dut2 W at done", W2, e.w);
                check("dut2 ovf at done", ovf2, e.ovf);
            end
        end
    end

    // Issue one run. Mode, base and step are scrambled while the run is in progress.
    task automatic run1(input logic [1:0] m, input logic [5:0] b, input logic [5:0] s,
                        input logic [5:0] ew, input logic eo, input bit hold, input bit post,
                        input string tag);
        int cyc;
        int bcnt;
        bit seen;
        @(negedge clk);
        start = 1'b1; mode = m; base = b; step = s;
        q1.push_back('{w: {2'b00, ew}, ovf: eo});
        @(posedge clk);
        cyc = 0; bcnt = 0; seen = 0;
        while (!seen && cyc <= 40) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            mode = ~m; base = ~b; step = ~s;
            if (busy) bcnt++;
            if (done) seen = 1;
            else cyc++;
        end
        start = 1'b0;
        check({tag, " done seen"}, seen, 1);
        check({tag, " latency"}, cyc, 11);
        check({tag, " busy cycles"}, bcnt, 11);
        if (post) begin
            repeat (2) begin
                @(negedge clk);
                check({tag, " idle after done"}, busy, 0);
                check({tag, " W holds"}, {26'd0, W}, {26'd0, ew});
            end
        end
    endtask

    initial begin
        int cyc;
        int dcnt;
        bit seen;
        reset = 1'b0; start = 1'b0; clear = 1'b0; mode = 2'b00; base = '0; step = '0;
        start2 = 1'b0; clear2 = 1'b0; mode2 = 2'b00; base2 = '0; step2 = '0;
        #12;
        check("reset W", {26'd0, W}, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset ovf", ovf, 0);
        @(negedge clk);
        reset = 1'b1;

        run1(2'b11, 6'd0, 6'd1, 6'd25, 1'b0, 0, 1, "legacy");
        run1(2'b00, 6'd0, 6'd1, 6'd55, 1'b0, 0, 1, "mode00");
        run1(2'b10, 6'd0, 6'd1, 6'd30, 1'b0, 0, 1, "mode10");
        run1(2'b01, 6'd0, 6'd1, 6'd25, 1'b0, 0, 1, "mode01");
        run1(2'b11, 6'd4, 6'd1, 6'd49, 1'b0, 0, 1, "legacy base4");
        run1(2'b01, 6'd4, 6'd1, 6'd45, 1'b0, 0, 1, "mode01 base4");
        run1(2'b00, 6'd10, 6'd3, 6'd19, 1'b1, 0, 1, "overflow");
        run1(2'b01, 6'd0, 6'd1, 6'd25, 1'b0, 0, 1, "ovf cleared");
        run1(2'b11, 6'd0, 6'd1, 6'd25, 1'b0, 1, 1, "start held");
        run1(2'b10, 6'd0, 6'd1, 6'd30, 1'b0, 0, 0, "b2b first");
        run1(2'b00, 6'd0, 6'd1, 6'd55, 1'b0, 0, 1, "b2b second");

        // start and clear together in IDLE: clear wins, so no run begins.
        @(negedge clk);
        start = 1'b1; clear = 1'b1;
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        check("start+clear busy", busy, 0);
        @(negedge clk);
        check("start+clear still idle", busy, 0);

        // Abort by clear while idx = 5.
        @(negedge clk);
        start = 1'b1; mode = 2'b00; base = 6'd10; step = 6'd3;
        @(posedge clk);
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            start = 1'b0; mode = 2'b01; base = 6'd0;
        end
        check("pre-clear W", {26'd0, W}, 16);
        check("pre-clear ovf", ovf, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear busy", busy, 0);
        check("clear W", {26'd0, W}, 0);
        check("clear ovf", ovf, 0);
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("clear no done", dcnt, 0);

        // Asynchronous reset between edges while idx = 7.
        @(negedge clk);
        start = 1'b1; mode = 2'b00; base = 6'd0; step = 6'd1;
        @(posedge clk);
        for (int i = 0; i <= 7; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre-reset W", {26'd0, W}, 21);
        #2 reset = 1'b0;
        #1;
        check("async reset W", {26'd0, W}, 0);
        check("async reset busy", busy, 0);
        check("async reset ovf", ovf, 0);
        @(negedge clk);
        reset = 1'b1;
        run1(2'b11, 6'd0, 6'd1, 6'd25, 1'b0, 0, 1, "after reset");

        // Corner case instance: W_WIDTH = 8, N_STEPS = 2. B wraps to 44, giving W = 244.
        @(negedge clk);
        start2 = 1'b1; mode2 = 2'b00; base2 = 8'd200; step2 = 8'd100;
        q2.push_back('{w: 8'd244, ovf: 1'b0});
        @(posedge clk);
        cyc = 0; seen = 0;
        while (!seen && cyc <= 20) begin
            @(negedge clk);
            start2 = 1'b0; base2 = 8'd1; step2 = 8'd1;
            if (done2) seen = 1;
            else cyc++;
        end
        check("corner done seen", seen, 1);
        check("corner latency", cyc, 2);

        repeat (3) @(negedge clk);
        check("dut queue drained", q1.size(), 0);
        check("dut2 queue drained", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
